// File: rtl/axi4l_mem_pkg.sv
// Shared types for the AXI4-Lite to memory bridge: channel structs, FSM states, response codes.
package axi4l_mem_pkg;

  localparam int unsigned AXI_ADDR_WIDTH = 32;
  localparam int unsigned AXI_DATA_WIDTH = 32;
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [2:0]                prot;
  } axi_aw_chan_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [AXI_STRB_WIDTH-1:0] strb;
  } axi_w_chan_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [2:0]                prot;
  } axi_ar_chan_t;

  typedef struct packed {
    logic [AXI_DATA_WIDTH-1:0] data;
    logic [1:0]                resp;
  } axi_r_chan_t;

  typedef struct packed {
    axi_aw_chan_t aw; logic aw_valid;
    axi_w_chan_t  w;  logic w_valid;
    logic         b_ready;
    axi_ar_chan_t ar; logic ar_valid;
    logic         r_ready;
  } axi_req_t;

  typedef struct packed {
    logic        aw_ready; logic w_ready;
    axi_b_chan_t b; logic b_valid;
    logic        ar_ready;
    axi_r_chan_t r; logic r_valid;
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    BRESP = 3'd3,
    RRESP = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4l_to_mem.sv
// AXI4-Lite subordinate that issues one single-beat SRAM-style access at a time,
// round-robin between reads and writes, with memory errors reported as SLVERR.
module axi4l_to_mem
  import axi4l_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter type axi_req_t  = axi4l_mem_pkg::axi_req_t,
  parameter type axi_resp_t = axi4l_mem_pkg::axi_resp_t
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  axi_req_t                axi_req_i,
  output axi_resp_t               axi_resp_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_strb_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_err_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFFS_WIDTH = $clog2(STRB_WIDTH);

  state_e                  state_q, state_d;
  logic                    aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic                    aw_ready_q, w_ready_q, ar_ready_q;
  logic [ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
  logic [2:0]              aw_prot_q, ar_prot_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_WIDTH-1:0]   w_strb_q;
  logic                    last_was_write_q, last_was_write_d, sel_write_q, sel_write_d;
  logic                    mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [STRB_WIDTH-1:0]   mem_strb_q, mem_strb_d;
  logic                    b_valid_q, b_valid_d, r_valid_q, r_valid_d;
  logic [1:0]              resp_q, resp_d;
  logic                    aw_hs, w_hs, ar_hs, aw_clr, w_clr, ar_clr, wr_elig, rd_elig;
  logic [ADDR_WIDTH-1:0]   aw_addr_al, ar_addr_al;

  // Protection bits are held for completeness but never steer the memory port.
  logic unused_prot;
  assign unused_prot = ^{aw_prot_q, ar_prot_q};

  assign aw_hs      = axi_req_i.aw_valid & aw_ready_q;
  assign w_hs       = axi_req_i.w_valid  & w_ready_q;
  assign ar_hs      = axi_req_i.ar_valid & ar_ready_q;
  assign wr_elig    = aw_full_q & w_full_q;
  assign rd_elig    = ar_full_q;
  assign aw_addr_al = {aw_addr_q[ADDR_WIDTH-1:OFFS_WIDTH], OFFS_WIDTH'(0)};
  assign ar_addr_al = {ar_addr_q[ADDR_WIDTH-1:OFFS_WIDTH], OFFS_WIDTH'(0)};

  // Next-state, arbitration, capture-flag and registered-output logic.
  always_comb begin
    state_d          = state_q;
    last_was_write_d = last_was_write_q;
    sel_write_d      = sel_write_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    mem_strb_d       = mem_strb_q;
    resp_d           = resp_q;
    rdata_d          = rdata_q;
    aw_clr           = 1'b0;
    w_clr            = 1'b0;
    ar_clr           = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_elig || rd_elig) begin
          sel_write_d = wr_elig && (!rd_elig || !last_was_write_q);
          state_d     = REQ;
          mem_we_d    = sel_write_d;
          mem_addr_d  = sel_write_d ? aw_addr_al : ar_addr_al;
          mem_wdata_d = sel_write_d ? w_data_q : '0;
          mem_strb_d  = sel_write_d ? w_strb_q : '1;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_d          = WAIT;
          last_was_write_d = sel_write_q;
          aw_clr           = sel_write_q;
          w_clr            = sel_write_q;
          ar_clr           = !sel_write_q;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          resp_d  = mem_err_i ? RESP_SLVERR : RESP_OKAY;
          rdata_d = mem_rdata_i;
          state_d = sel_write_q ? BRESP : RRESP;
        end
      end
      BRESP:   if (axi_req_i.b_ready) state_d = IDLE;
      RRESP:   if (axi_req_i.r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A clear wins over a capture; ready can only rise on the following cycle.
    aw_full_d = aw_clr ? 1'b0 : (aw_full_q | aw_hs);
    w_full_d  = w_clr  ? 1'b0 : (w_full_q  | w_hs);
    ar_full_d = ar_clr ? 1'b0 : (ar_full_q | ar_hs);
    mem_req_d = (state_d == REQ);
    b_valid_d = (state_d == BRESP);
    r_valid_d = (state_d == RRESP);
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q          <= IDLE;
      aw_full_q        <= 1'b0;
      w_full_q         <= 1'b0;
      ar_full_q        <= 1'b0;
      aw_ready_q       <= 1'b0;
      w_ready_q        <= 1'b0;
      ar_ready_q       <= 1'b0;
      aw_addr_q        <= '0;
      aw_prot_q        <= '0;
      ar_addr_q        <= '0;
      ar_prot_q        <= '0;
      w_data_q         <= '0;
      w_strb_q         <= '0;
      last_was_write_q <= 1'b1;
      sel_write_q      <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      mem_strb_q       <= '0;
      b_valid_q        <= 1'b0;
      r_valid_q        <= 1'b0;
      resp_q           <= '0;
      rdata_q          <= '0;
    end else begin
      state_q          <= state_d;
      aw_full_q        <= aw_full_d;
      w_full_q         <= w_full_d;
      ar_full_q        <= ar_full_d;
      aw_ready_q       <= !aw_full_d;
      w_ready_q        <= !w_full_d;
      ar_ready_q       <= !ar_full_d;
      if (aw_hs) begin
        aw_addr_q <= axi_req_i.aw.addr;
        aw_prot_q <= axi_req_i.aw.prot;
      end
      if (w_hs) begin
        w_data_q <= axi_req_i.w.data;
        w_strb_q <= axi_req_i.w.strb;
      end
      if (ar_hs) begin
        ar_addr_q <= axi_req_i.ar.addr;
        ar_prot_q <= axi_req_i.ar.prot;
      end
      last_was_write_q <= last_was_write_d;
      sel_write_q      <= sel_write_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      mem_strb_q       <= mem_strb_d;
      b_valid_q        <= b_valid_d;
      r_valid_q        <= r_valid_d;
      resp_q           <= resp_d;
      rdata_q          <= rdata_d;
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready_q;
    axi_resp_o.w_ready  = w_ready_q;
    axi_resp_o.ar_ready = ar_ready_q;
    axi_resp_o.b_valid  = b_valid_q;
    axi_resp_o.b.resp   = resp_q;
    axi_resp_o.r_valid  = r_valid_q;
    axi_resp_o.r.resp   = resp_q;
    axi_resp_o.r.data   = rdata_q;
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_strb_o  = mem_strb_q;

endmodule

// File: tb/tb_axi4l_to_mem.sv
// Directed bench for axi4l_to_mem: latency, arbitration, ordering, backpressure and reset.
module tb_axi4l_to_mem;
  import axi4l_mem_pkg::*;

  logic        clk_i;
  logic        arst_ni;
  axi_req_t    req;
  axi_resp_t   resp;
  logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, mem_err_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_strb_o;
  int          checks;
  int          errors;

  axi4l_to_mem #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .axi_req_t (axi_req_t),
    .axi_resp_t(axi_resp_t)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .axi_req_i   (req),
    .axi_resp_o  (resp),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_strb_o  (mem_strb_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .mem_err_i   (mem_err_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Waits for a request, checks it, grants it (gnt held high), answers one cycle later and checks B/R.
  task automatic mem_cycle(input logic exp_we, input logic [31:0] exp_addr,
                           input logic [31:0] rdata, input logic err, input string tag);
    int n = 0;
    while (!mem_req_o && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 64'(mem_req_o), 64'd1);
    chk({tag, "_we"}, 64'(mem_we_o), 64'(exp_we));
    chk({tag, "_addr"}, 64'(mem_addr_o), 64'(exp_addr));
    tick();
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rdata;
    mem_err_i    = err;
    tick();
    mem_rvalid_i = 1'b0;
    mem_err_i    = 1'b0;
    if (exp_we) begin
      chk({tag, "_bvalid"}, 64'(resp.b_valid), 64'd1);
      chk({tag, "_bresp"}, 64'(resp.b.resp), err ? 64'd2 : 64'd0);
    end else begin
      chk({tag, "_rvalid"}, 64'(resp.r_valid), 64'd1);
      chk({tag, "_rdata"}, 64'(resp.r.data), 64'(rdata));
      chk({tag, "_rresp"}, 64'(resp.r.resp), err ? 64'd2 : 64'd0);
    end
    tick();
  endtask

  initial begin
    logic ok;
    int   reqs;
    checks       = 0;
    errors       = 0;
    arst_ni      = 1'b0;
    req          = '0;
    req.b_ready  = 1'b1;
    req.r_ready  = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_resp", 64'(resp), 64'd0);
    chk("rst_mem_ctl", 64'({mem_req_o, mem_we_o, mem_strb_o}), 64'd0);
    arst_ni = 1'b1;
    chk("rst_ready_before_edge", 64'(resp.aw_ready), 64'd0);
    tick();
    chk("rst_ready_after_edge", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready}), 64'h7);

    // Tie straight out of reset: read first, then write
    req.ar.addr = 32'h8;  req.ar_valid = 1'b1;
    req.aw.addr = 32'h4;  req.aw_valid = 1'b1;
    req.w.data  = 32'hA5A5_A5A5; req.w.strb = 4'hF; req.w_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
    mem_cycle(1'b0, 32'h8, 32'h1111_2222, 1'b0, "tie1_rd");
    mem_cycle(1'b1, 32'h4, 32'h0, 1'b0, "tie1_wr");

    // Single write with minimum latency
    req.aw.addr = 32'h13; req.aw_valid = 1'b1;
    req.w.data  = 32'hDEAD_BEEF; req.w.strb = 4'b0110; req.w_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    chk("wr_aw_ready_low", 64'({resp.aw_ready, resp.w_ready}), 64'd0);
    chk("wr_t0_noreq", 64'(mem_req_o), 64'd0);
    tick();
    chk("wr_t1_req", 64'(mem_req_o), 64'd1);
    chk("wr_t1_we", 64'(mem_we_o), 64'd1);
    chk("wr_t1_addr", 64'(mem_addr_o), 64'h10);
    chk("wr_t1_data", 64'(mem_wdata_o), 64'hDEAD_BEEF);
    chk("wr_t1_strb", 64'(mem_strb_o), 64'h6);
    tick();
    chk("wr_t2_wait", 64'({mem_req_o, resp.b_valid}), 64'd0);
    mem_rvalid_i = 1'b1; mem_err_i = 1'b0; mem_rdata_i = 32'h0;
    tick();
    mem_rvalid_i = 1'b0;
    chk("wr_t3_bvalid", 64'(resp.b_valid), 64'd1);
    chk("wr_t3_bresp", 64'(resp.b.resp), 64'd0);
    chk("wr_t3_aw_ready", 64'(resp.aw_ready), 64'd1);
    tick();
    chk("wr_t4_bvalid_drop", 64'(resp.b_valid), 64'd0);

    // Read with memory error -> SLVERR
    req.ar.addr = 32'h40; req.ar_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    mem_cycle(1'b0, 32'h40, 32'h1234_5678, 1'b1, "rderr");
    chk("rderr_strb", 64'(mem_strb_o), 64'hF);

    // Tie again after a read: write first
    req.ar.addr = 32'h8;  req.ar_valid = 1'b1;
    req.aw.addr = 32'h4;  req.aw_valid = 1'b1;
    req.w.data  = 32'h5A5A_5A5A; req.w.strb = 4'hF; req.w_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0; req.aw_valid = 1'b0; req.w_valid = 1'b0;
    mem_cycle(1'b1, 32'h4, 32'h0, 1'b0, "tie2_wr");
    mem_cycle(1'b0, 32'h8, 32'h5555_AAAA, 1'b0, "tie2_rd");

    // W three cycles ahead of AW, grant delayed five cycles
    mem_gnt_i = 1'b0;
    req.w.data = 32'hCAFE_F00D; req.w.strb = 4'hF; req.w_valid = 1'b1;
    tick();
    req.w_valid = 1'b0;
    chk("wfirst_w_ready_low", 64'(resp.w_ready), 64'd0);
    reqs = 0;
    for (int i = 0; i < 2; i++) begin
      if (mem_req_o) reqs++;
      tick();
    end
    req.aw.addr = 32'h22; req.aw_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0;
    if (mem_req_o) reqs++;
    chk("wfirst_no_early_req", 64'(reqs), 64'd0);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ok &= (mem_req_o === 1'b1) && (mem_we_o === 1'b1) && (mem_addr_o === 32'h20) &&
            (mem_wdata_o === 32'hCAFE_F00D) && (mem_strb_o === 4'hF);
      if (i == 5) mem_gnt_i = 1'b1;
      tick();
    end
    chk("wfirst_req_stable", 64'(ok), 64'd1);
    chk("wfirst_req_drop", 64'(mem_req_o), 64'd0);
    mem_rvalid_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0;
    chk("wfirst_bvalid", 64'(resp.b_valid), 64'd1);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_req_o) reqs++;
    end
    chk("wfirst_single_write", 64'(reqs), 64'd0);

    // B backpressure with a read waiting
    req.b_ready = 1'b0;
    req.aw.addr = 32'h30; req.aw_valid = 1'b1;
    req.w.data  = 32'h0BAD_F00D; req.w.strb = 4'h3; req.w_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    req.ar.addr = 32'h50; req.ar_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    chk("bp_req_we", 64'({mem_req_o, mem_we_o}), 64'h3);
    tick();
    mem_rvalid_i = 1'b1; mem_err_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ok &= (resp.b_valid === 1'b1) && (resp.b.resp === 2'b10) && (mem_req_o === 1'b0);
      tick();
    end
    chk("bp_stable", 64'(ok), 64'd1);
    req.b_ready = 1'b1;
    tick();
    chk("bp_bvalid_drop", 64'(resp.b_valid), 64'd0);
    mem_cycle(1'b0, 32'h50, 32'h0F0F_0F0F, 1'b0, "bp_rd");

    // Reset while waiting for the memory response
    req.ar.addr = 32'h60; req.ar_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    tick();
    chk("rstw_req", 64'(mem_req_o), 64'd1);
    tick();
    arst_ni = 1'b0;
    #1;
    chk("rstw_resp_zero", 64'(resp), 64'd0);
    chk("rstw_mem_ctl", 64'({mem_req_o, mem_we_o, mem_strb_o}), 64'd0);
    chk("rstw_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rstw_mem_wdata", 64'(mem_wdata_o), 64'd0);
    tick();
    chk("rstw_resp_held", 64'(resp), 64'd0);
    arst_ni = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777; mem_err_i = 1'b1;
    tick();
    mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
    chk("rstw_ready_after_release", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready}), 64'h7);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ok &= (resp.r_valid === 1'b0) && (resp.b_valid === 1'b0) && (mem_req_o === 1'b0);
      tick();
    end
    chk("rstw_no_late_beat", 64'(ok), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
